// File: rtl/pixel_hfilter_3tap_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_hfilter_3tap_if : Avalon-ST sink/source bundle for the 3-tap filter  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pixel_hfilter_3tap_if;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;

  // slave = the filter stage itself, master = its surrounding environment
  modport slave (
    input  sink_data, sink_valid, sink_sop, sink_eop, source_ready,
    output sink_ready, source_data, source_valid, source_sop, source_eop
  );
  modport master (
    output sink_data, sink_valid, sink_sop, sink_eop, source_ready,
    input  sink_ready, source_data, source_valid, source_sop, source_eop
  );
endinterface
`default_nettype wire

// File: rtl/pixel_hfilter_3tap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_hfilter_3tap : horizontal [1 2 1]/4 per-channel Avalon-ST filter     |
// | Optional macro PIX_HFILTER_STATS_EN builds the frame_pixels counter.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pixel_hfilter_3tap #(
  parameter int IMAGE_W     = 640,
  parameter int ABORT_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pixel_hfilter_3tap_if.slave    st,
  input  logic                   enable,
  output logic [ABORT_CNT_W-1:0] aborted_frames,
  output logic [19:0]            frame_pixels
);

  localparam int X_W = $clog2(IMAGE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VIDEO = 2'd1,
    S_PASS  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                 r_state;
  logic [23:0]            r_out_data;
  logic                   r_out_valid;
  logic                   r_out_sop;
  logic                   r_out_eop;
  logic [X_W-1:0]         r_x;
  logic                   r_pend;
  logic [23:0]            r_p;
  logic [23:0]            r_c;
  logic                   r_eop_st;
  logic [ABORT_CNT_W-1:0] r_abort;

  logic w_out_free;
  logic w_acc;
  logic w_last;

  function automatic logic [23:0] filt(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    logic [9:0]  s;
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = {2'b00, a[8*k +: 8]} + {1'b0, b[8*k +: 8], 1'b0} + {2'b00, c[8*k +: 8]} + 10'd2;
      r[8*k +: 8] = s[9:2];
    end
    return r;
  endfunction

  assign w_out_free      = ~r_out_valid | st.source_ready;
  assign st.sink_ready   = w_out_free & (r_state != S_FLUSH);
  assign w_acc           = st.sink_valid & st.sink_ready;
  assign w_last          = (r_x == X_W'(IMAGE_W - 1));

  assign st.source_data  = r_out_data;
  assign st.source_valid = r_out_valid;
  assign st.source_sop   = r_out_sop;
  assign st.source_eop   = r_out_eop;
  assign aborted_frames  = r_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_x         <= '0;
      r_pend      <= 1'b0;
      r_p         <= '0;
      r_c         <= '0;
      r_eop_st    <= 1'b0;
      r_abort     <= '0;
    end else begin
      if (w_out_free) r_out_valid <= 1'b0;

      if (w_acc && st.sink_sop) begin
        // Header beat: echoed as-is; an open video frame is abandoned here
        r_out_valid <= 1'b1;
        r_out_data  <= st.sink_data;
        r_out_sop   <= 1'b1;
        r_out_eop   <= st.sink_eop;
        r_pend      <= 1'b0;
        r_x         <= '0;
        if (r_state == S_VIDEO && r_abort != {ABORT_CNT_W{1'b1}})
          r_abort <= r_abort + ABORT_CNT_W'(1);
        if (st.sink_data[3:0] == 4'h0 && enable && !st.sink_eop)
          r_state <= S_VIDEO;
        else if (st.sink_eop)
          r_state <= S_IDLE;
        else
          r_state <= S_PASS;
      end else begin
        case (r_state)
          S_VIDEO: begin
            if (w_acc) begin
              r_c <= st.sink_data;
              r_x <= r_x + X_W'(1);
              if (r_pend) begin
                r_out_valid <= 1'b1;
                r_out_data  <= filt(r_p, r_c, st.sink_data);
                r_out_sop   <= 1'b0;
                r_out_eop   <= 1'b0;
                r_p         <= r_c;
              end else begin
                r_p    <= st.sink_data;
                r_pend <= 1'b1;
              end
              if (w_last || st.sink_eop) begin
                r_state  <= S_FLUSH;
                r_eop_st <= st.sink_eop;
              end
            end
          end
          S_FLUSH: begin
            // Right edge replicates the last pixel
            if (w_out_free) begin
              r_out_valid <= 1'b1;
              r_out_data  <= filt(r_p, r_c, r_c);
              r_out_sop   <= 1'b0;
              r_out_eop   <= r_eop_st;
              r_pend      <= 1'b0;
              r_x         <= '0;
              r_state     <= r_eop_st ? S_IDLE : S_VIDEO;
            end
          end
          default: begin
            if (w_acc) begin
              r_out_valid <= 1'b1;
              r_out_data  <= st.sink_data;
              r_out_sop   <= 1'b0;
              r_out_eop   <= st.sink_eop;
              if (r_state == S_PASS && st.sink_eop) r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

`ifdef PIX_HFILTER_STATS_EN
  logic [19:0] r_pix_cnt;
  logic [19:0] r_frame_pixels;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_cnt      <= '0;
      r_frame_pixels <= '0;
    end else if (w_acc) begin
      if (st.sink_sop) begin
        r_pix_cnt <= '0;
      end else if (r_state == S_VIDEO) begin
        r_pix_cnt <= r_pix_cnt + 20'd1;
        if (st.sink_eop) r_frame_pixels <= r_pix_cnt + 20'd1;
      end
    end
  end

  assign frame_pixels = r_frame_pixels;
`else
  assign frame_pixels = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_hfilter_3tap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_hfilter_3tap : scoreboard bench for pixel_hfilter_3tap            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pixel_hfilter_3tap;
  localparam int IMAGE_W     = 640;
  localparam int ABORT_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   enable = 1'b0;
  logic [ABORT_CNT_W-1:0] aborted_frames;
  logic [19:0]            frame_pixels;

  pixel_hfilter_3tap_if bus ();

  pixel_hfilter_3tap #(.IMAGE_W(IMAGE_W), .ABORT_CNT_W(ABORT_CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .st             (bus.slave),
    .enable         (enable),
    .aborted_frames (aborted_frames),
    .frame_pixels   (frame_pixels)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    stall_pct = 0;
  int    gap_pct = 0;
  bit    mon_en = 1'b1;
  int    exp_abort = 0;
  int    exp_fp = 0;

  beat_t mon_got, mon_exp, held;
  bit    held_v = 1'b0;

  initial begin
    bus.source_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.source_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      mon_got = {bus.source_data, bus.source_sop, bus.source_eop};
      if (held_v) begin
        total++;
        if (!bus.source_valid || mon_got != held) begin
          bad++;
          $display("FAIL hold: got v=%0b %h s=%0b e=%0b want v=1 %h s=%0b e=%0b",
                   bus.source_valid, mon_got.d, mon_got.s, mon_got.e, held.d, held.s, held.e);
        end
      end
      held_v = bus.source_valid && !bus.source_ready;
      held   = mon_got;
      if (bus.source_valid && bus.source_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra beat: got %h s=%0b e=%0b want none", mon_got.d, mon_got.s, mon_got.e);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL beat: got %h s=%0b e=%0b want %h s=%0b e=%0b",
                     mon_got.d, mon_got.s, mon_got.e, mon_exp.d, mon_exp.s, mon_exp.e);
          end
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference per-channel [1 2 1]/4 with rounding
  function automatic logic [23:0] mfilt(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c);
    logic [23:0] r;
    int          v;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      v = (int'(a[8*k +: 8]) + 2 * int'(b[8*k +: 8]) + int'(c[8*k +: 8]) + 2) / 4;
      r[8*k +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      bus.sink_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.sink_valid = 1'b1;
    bus.sink_data  = d;
    bus.sink_sop   = s;
    bus.sink_eop   = e;
    guard = 0;
    @(negedge clk);
    while (!bus.sink_ready) begin
      guard++;
      if (guard > 2000) begin
        $display("FAIL sink_ready: got stuck low want accept");
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.sink_valid = 1'b0;
  endtask

  // mode: 0 random, 1 R impulse at index 2, 2 flat 200
  task automatic send_packet(input logic [23:0] hdr, input bit en, input int npix,
                             input bit end_eop, input int mode);
    logic [23:0] px[$];
    logic [23:0] a, c;
    bit          is_video, complete;
    int          le;
    px = {};
    for (int i = 0; i < npix; i++) begin
      case (mode)
        1:       px.push_back((i == 2) ? 24'hFF0000 : 24'h000000);
        2:       px.push_back(24'hC8C8C8);
        default: px.push_back(24'($urandom()));
      endcase
    end
    is_video = (hdr[3:0] == 4'h0) && en && !(npix == 0 && end_eop);
    exp_q.push_back({hdr, 1'b1, (npix == 0) && end_eop});
    if (!is_video) begin
      for (int i = 0; i < npix; i++)
        exp_q.push_back({px[i], 1'b0, end_eop && (i == npix - 1)});
    end else begin
      for (int ls = 0; ls < npix; ls += IMAGE_W) begin
        le = ((ls + IMAGE_W) < npix ? (ls + IMAGE_W) : npix) - 1;
        complete = ((le - ls + 1) == IMAGE_W) || ((le == npix - 1) && end_eop);
        for (int i = ls; i <= le; i++) begin
          if (complete || i != le) begin
            a = (i == ls) ? px[i] : px[i-1];
            c = (i == le) ? px[i] : px[i+1];
            exp_q.push_back({mfilt(a, px[i], c), 1'b0, end_eop && (i == npix - 1)});
          end
        end
      end
      if (!end_eop) exp_abort++;
      else          exp_fp = npix;
    end
    enable = en;
    send_beat(hdr, 1'b1, (npix == 0) && end_eop);
    for (int i = 0; i < npix; i++) begin
      enable = 1'($urandom_range(1));
      send_beat(px[i], 1'b0, end_eop && (i == npix - 1));
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_fp(input string name);
`ifdef PIX_HFILTER_STATS_EN
    chk(name, frame_pixels, exp_fp);
`else
    chk(name, frame_pixels, 0);
`endif
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] h;
    bus.sink_valid = 1'b0;
    bus.sink_data  = '0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_source_valid", bus.source_valid, 0);
    chk("rst_source_data", bus.source_data, 0);
    chk("rst_sink_ready", bus.sink_ready, 1);
    chk("rst_aborted", aborted_frames, 0);
    chk("rst_frame_pixels", frame_pixels, 0);

    send_packet(24'h000000, 1'b1, IMAGE_W, 1'b1, 1);
    drain();
    chk_fp("fp_impulse");

    send_packet(24'h00000F, 1'b1, 3, 1'b1, 0);
    drain();
    chk("aborted_ctrl", aborted_frames, 0);

    // stray non-SOP data while idle
    for (int i = 0; i < 2; i++) begin
      r = $urandom();
      exp_q.push_back({r[23:0], 1'b0, r[24]});
      send_beat(r[23:0], 1'b0, r[24]);
    end
    drain();

    send_packet(24'h123450, 1'b0, 50, 1'b1, 0);
    drain();

    stall_pct = 30;
    send_packet(24'h000000, 1'b1, IMAGE_W, 1'b1, 2);
    drain();

    send_packet(24'hABCD00, 1'b1, 100, 1'b0, 0);
    send_packet(24'h000000, 1'b1, IMAGE_W + 20, 1'b1, 0);
    drain();
    chk("aborted_one", aborted_frames, exp_abort);

    gap_pct = 20;
    for (int p = 0; p < 6; p++) begin
      r = $urandom();
      if (r[31:30] == 2'd0) h = {r[23:4], 4'(1 + $urandom_range(14))};
      else                  h = {r[23:4], 4'h0};
      send_packet(h, 1'($urandom_range(3) != 0), $urandom_range(1, 700),
                  (p == 5) ? 1'b1 : 1'($urandom_range(3) != 0), 0);
    end
    drain();
    chk("aborted_random", aborted_frames, exp_abort);

    send_packet(24'h000000, 1'b1, 3 * IMAGE_W, 1'b1, 0);
    drain();
    chk_fp("fp_three_lines");
    chk("aborted_after_lines", aborted_frames, exp_abort);

    // reset pulse in the middle of a line
    mon_en    = 1'b0;
    stall_pct = 0;
    gap_pct   = 0;
    enable    = 1'b1;
    send_beat(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_beat(24'($urandom()), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_source_valid", bus.source_valid, 0);
    chk("midrst_aborted", aborted_frames, 0);
    chk("midrst_frame_pixels", frame_pixels, 0);
    exp_abort = 0;
    exp_fp    = 0;
    mon_en    = 1'b1;
    send_packet(24'h000000, 1'b1, 30, 1'b1, 0);
    drain();
    chk("post_rst_aborted", aborted_frames, exp_abort);
    chk_fp("fp_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
